// File: rtl/instruction_fetch_controller.sv
// Instruction fetch controller: owns the PC, drives the asynchronous-read ROM
// and registers the returned word for decode. Handles stall, jump/branch
// redirects, a HALT word and address faults.
module instruction_fetch_controller #(
    parameter int unsigned           MEMORY_DEPTH = 32,
    parameter int unsigned           DATA_WIDTH   = 32,
    parameter logic [DATA_WIDTH-1:0] RESET_VECTOR = '0,
    parameter logic [DATA_WIDTH-1:0] HALT_WORD    = DATA_WIDTH'(32'h0000000C)
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  Stall,
    input  logic                  Jump,
    input  logic [DATA_WIDTH-1:0] JumpTarget,
    input  logic                  BranchTaken,
    input  logic [DATA_WIDTH-1:0] BranchTarget,
    input  logic                  Resume,
    input  logic [DATA_WIDTH-1:0] Instruction,
    output logic [DATA_WIDTH-1:0] Address,
    output logic [DATA_WIDTH-1:0] InstructionOut,
    output logic [DATA_WIDTH-1:0] PCOut,
    output logic [DATA_WIDTH-1:0] PCPlus4,
    output logic                  InstrValid,
    output logic                  Halted,
    output logic                  Fault,
    output logic [1:0]            FaultCause,
    output logic [DATA_WIDTH-1:0] FaultPC
);

    // First byte address past the end of the ROM.
    localparam logic [DATA_WIDTH-1:0] ADDR_LIMIT = DATA_WIDTH'(MEMORY_DEPTH * 4);

    localparam logic [1:0] CAUSE_NONE      = 2'b00;
    localparam logic [1:0] CAUSE_MISALIGN  = 2'b01;
    localparam logic [1:0] CAUSE_OUT_RANGE = 2'b10;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        HALT  = 2'd2,
        FAULT = 2'd3
    } state_t;

    state_t                state;
    logic [DATA_WIDTH-1:0] pc;
    logic                  misaligned;
    logic                  out_of_range;

    // Fault classification of the PC currently presented to the ROM.
    assign misaligned   = (pc[1:0] != 2'b00);
    assign out_of_range = (pc >= ADDR_LIMIT);

    // ROM address tracks the PC; status flags decode straight from state.
    assign Address = pc;
    assign PCPlus4 = PCOut + DATA_WIDTH'(4);
    assign Halted  = (state == HALT);
    assign Fault   = (state == FAULT);

    // Fetch sequencer: PC, fetch register and fault capture.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state          <= IDLE;
            pc             <= RESET_VECTOR;
            InstructionOut <= '0;
            PCOut          <= '0;
            InstrValid     <= 1'b0;
            FaultCause     <= CAUSE_NONE;
            FaultPC        <= '0;
        end else begin
            case (state)
                IDLE: begin
                    InstrValid <= 1'b0;
                    state      <= RUN;
                end
                RUN: begin
                    if (misaligned || out_of_range) begin
                        // Misaligned takes precedence when both apply.
                        FaultPC    <= pc;
                        FaultCause <= misaligned ? CAUSE_MISALIGN : CAUSE_OUT_RANGE;
                        InstrValid <= 1'b0;
                        state      <= FAULT;
                    end else if (Jump) begin
                        pc         <= JumpTarget;
                        InstrValid <= 1'b0;
                    end else if (BranchTaken) begin
                        pc         <= BranchTarget;
                        InstrValid <= 1'b0;
                    end else if (!Stall) begin
                        InstructionOut <= Instruction;
                        PCOut          <= pc;
                        InstrValid     <= 1'b1;
                        pc             <= pc + DATA_WIDTH'(4);
                        if (Instruction == HALT_WORD) begin
                            state <= HALT;
                        end
                    end
                end
                HALT: begin
                    InstrValid <= 1'b0;
                    if (Resume) begin
                        state <= RUN;
                    end
                end
                FAULT: begin
                    InstrValid <= 1'b0;
                    if (Resume) begin
                        pc         <= RESET_VECTOR;
                        FaultCause <= CAUSE_NONE;
                        state      <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_instruction_fetch_controller.sv
// Bench for instruction_fetch_controller: directed vector table, an
// asynchronous reset check in FAULT, and a randomized run against a model.
module tb_instruction_fetch_controller;

    localparam int unsigned DEPTH = 32;
    localparam int unsigned DW    = 32;
    localparam logic [31:0] HALTW = 32'h0000000C;
    localparam int unsigned NRAND = 1500;

    logic        clk = 1'b0;
    logic        reset;
    logic        Stall, Jump, BranchTaken, Resume;
    logic [31:0] JumpTarget, BranchTarget, Instruction;
    logic [31:0] Address, InstructionOut, PCOut, PCPlus4, FaultPC;
    logic        InstrValid, Halted, Fault;
    logic [1:0]  FaultCause;

    logic [31:0] rom [DEPTH];

    int errors = 0;
    int checks = 0;

    instruction_fetch_controller #(
        .MEMORY_DEPTH(DEPTH),
        .DATA_WIDTH  (DW),
        .RESET_VECTOR(32'h0),
        .HALT_WORD   (HALTW)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .Stall         (Stall),
        .Jump          (Jump),
        .JumpTarget    (JumpTarget),
        .BranchTaken   (BranchTaken),
        .BranchTarget  (BranchTarget),
        .Resume        (Resume),
        .Instruction   (Instruction),
        .Address       (Address),
        .InstructionOut(InstructionOut),
        .PCOut         (PCOut),
        .PCPlus4       (PCPlus4),
        .InstrValid    (InstrValid),
        .Halted        (Halted),
        .Fault         (Fault),
        .FaultCause    (FaultCause),
        .FaultPC       (FaultPC)
    );

    always #5 clk = ~clk;

    // Asynchronous-read ROM; illegal addresses return a recognisable junk word.
    assign Instruction = (Address[1:0] == 2'b00 && Address < DEPTH * 4) ? rom[Address[6:2]]
                                                                        : 32'hBAD0BAD0;

    typedef struct {
        logic        stall;
        logic        jump;
        logic [31:0] jt;
        logic        br;
        logic [31:0] bt;
        logic        resume;
        logic [31:0] addr;
        logic        valid;
        logic [31:0] pcout;
        logic [31:0] iout;
        logic        halted;
        logic        fault;
        logic [1:0]  cause;
        logic [31:0] fpc;
    } vec_t;

    localparam int NVEC = 24;
    vec_t vecs [NVEC];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic check_outputs(input string tag, input logic [31:0] addr, input logic valid,
                                 input logic [31:0] pcout, input logic [31:0] iout,
                                 input logic halted, input logic fault,
                                 input logic [1:0] cause, input logic [31:0] fpc);
        check({tag, ".Address"},        Address,               addr);
        check({tag, ".InstrValid"},     32'(InstrValid),       32'(valid));
        check({tag, ".PCOut"},          PCOut,                 pcout);
        check({tag, ".PCPlus4"},        PCPlus4,               pcout + 32'd4);
        check({tag, ".InstructionOut"}, InstructionOut,        iout);
        check({tag, ".Halted"},         32'(Halted),           32'(halted));
        check({tag, ".Fault"},          32'(Fault),            32'(fault));
        check({tag, ".FaultCause"},     32'(FaultCause),       32'(cause));
        if (fault) check({tag, ".FaultPC"}, FaultPC, fpc);
    endtask

    // Behavioural model state: mode 0 idle, 1 run, 2 halted, 3 faulted.
    int          m_mode;
    logic [31:0] m_pc, m_pcout, m_iout, m_fpc;
    logic        m_valid;
    logic [1:0]  m_cause;

    function automatic logic [1:0] fault_kind(input logic [31:0] pc);
        if (pc % 4 != 0)     return 2'd1;
        if (pc >= DEPTH * 4) return 2'd2;
        return 2'd0;
    endfunction

    task automatic model_reset();
        m_mode = 0; m_pc = 32'h0; m_pcout = 32'h0; m_iout = 32'h0;
        m_fpc = 32'h0; m_valid = 1'b0; m_cause = 2'd0;
    endtask

    task automatic model_step(input logic st, input logic jp, input logic [31:0] jt,
                              input logic br, input logic [31:0] bt, input logic rs);
        logic [1:0] k;
        case (m_mode)
            0: begin m_valid = 1'b0; m_mode = 1; end
            1: begin
                k = fault_kind(m_pc);
                if (k != 2'd0) begin
                    m_fpc = m_pc; m_cause = k; m_valid = 1'b0; m_mode = 3;
                end else if (jp || br) begin
                    m_pc = jp ? jt : bt; m_valid = 1'b0;
                end else if (!st) begin
                    m_iout  = rom[m_pc / 4];
                    m_pcout = m_pc;
                    m_valid = 1'b1;
                    m_pc    = m_pc + 32'd4;
                    if (m_iout == HALTW) m_mode = 2;
                end
            end
            2: begin m_valid = 1'b0; if (rs) m_mode = 1; end
            default: begin
                m_valid = 1'b0;
                if (rs) begin m_pc = 32'h0; m_cause = 2'd0; m_mode = 0; end
            end
        endcase
    endtask

    function automatic logic [31:0] rand_target();
        logic [31:0] t;
        t = 32'($urandom_range(0, 35)) << 2;
        if ($urandom_range(0, 7) == 0) t = t | 32'($urandom_range(1, 3));
        return t;
    endfunction

    initial begin
        reset = 1'b1; Stall = 1'b0; Jump = 1'b0; BranchTaken = 1'b0; Resume = 1'b0;
        JumpTarget = 32'h0; BranchTarget = 32'h0;

        for (int i = 0; i < int'(DEPTH); i++) rom[i] = 32'h20000000 | 32'(i);
        rom[0] = 32'h20080001;
        rom[1] = 32'h20090002;
        rom[4] = HALTW;

        //            s  j  jt     b  bt     r  addr   v  pcout  iout         h  f  c  fpc
        vecs[0]  = '{0, 0, 32'h0,  0, 32'h0,  0, 32'h0,  0, 32'h0,  32'h0,        0, 0, 0, 32'h0};
        vecs[1]  = '{0, 0, 32'h0,  0, 32'h0,  0, 32'h4,  1, 32'h0,  32'h20080001, 0, 0, 0, 32'h0};
        vecs[2]  = '{0, 0, 32'h0,  0, 32'h0,  0, 32'h8,  1, 32'h4,  32'h20090002, 0, 0, 0, 32'h0};
        vecs[3]  = '{1, 0, 32'h0,  0, 32'h0,  0, 32'h8,  1, 32'h4,  32'h20090002, 0, 0, 0, 32'h0};
        vecs[4]  = '{1, 0, 32'h0,  0, 32'h0,  0, 32'h8,  1, 32'h4,  32'h20090002, 0, 0, 0, 32'h0};
        vecs[5]  = '{1, 0, 32'h0,  0, 32'h0,  0, 32'h8,  1, 32'h4,  32'h20090002, 0, 0, 0, 32'h0};
        vecs[6]  = '{0, 0, 32'h0,  0, 32'h0,  0, 32'hC,  1, 32'h8,  32'h20000002, 0, 0, 0, 32'h0};
        vecs[7]  = '{1, 1, 32'h40, 1, 32'h20, 0, 32'h40, 0, 32'h8,  32'h20000002, 0, 0, 0, 32'h0};
        vecs[8]  = '{0, 0, 32'h0,  0, 32'h0,  0, 32'h44, 1, 32'h40, 32'h20000010, 0, 0, 0, 32'h0};
        vecs[9]  = '{0, 0, 32'h0,  1, 32'h10, 0, 32'h10, 0, 32'h40, 32'h20000010, 0, 0, 0, 32'h0};
        vecs[10] = '{0, 0, 32'h0,  0, 32'h0,  0, 32'h14, 1, 32'h10, 32'h0000000C, 1, 0, 0, 32'h0};
        vecs[11] = '{1, 1, 32'h40, 0, 32'h0,  0, 32'h14, 0, 32'h10, 32'h0000000C, 1, 0, 0, 32'h0};
        vecs[12] = '{0, 0, 32'h0,  0, 32'h0,  0, 32'h14, 0, 32'h10, 32'h0000000C, 1, 0, 0, 32'h0};
        vecs[13] = '{0, 0, 32'h0,  0, 32'h0,  1, 32'h14, 0, 32'h10, 32'h0000000C, 0, 0, 0, 32'h0};
        vecs[14] = '{0, 0, 32'h0,  0, 32'h0,  0, 32'h18, 1, 32'h14, 32'h20000005, 0, 0, 0, 32'h0};
        vecs[15] = '{0, 1, 32'h42, 0, 32'h0,  0, 32'h42, 0, 32'h14, 32'h20000005, 0, 0, 0, 32'h0};
        vecs[16] = '{0, 0, 32'h0,  0, 32'h0,  0, 32'h42, 0, 32'h14, 32'h20000005, 0, 1, 1, 32'h42};
        vecs[17] = '{1, 1, 32'h8,  0, 32'h0,  0, 32'h42, 0, 32'h14, 32'h20000005, 0, 1, 1, 32'h42};
        vecs[18] = '{0, 0, 32'h0,  0, 32'h0,  1, 32'h0,  0, 32'h14, 32'h20000005, 0, 0, 0, 32'h0};
        vecs[19] = '{0, 0, 32'h0,  0, 32'h0,  0, 32'h0,  0, 32'h14, 32'h20000005, 0, 0, 0, 32'h0};
        vecs[20] = '{0, 0, 32'h0,  0, 32'h0,  0, 32'h4,  1, 32'h0,  32'h20080001, 0, 0, 0, 32'h0};
        vecs[21] = '{0, 1, 32'h7C, 0, 32'h0,  0, 32'h7C, 0, 32'h0,  32'h20080001, 0, 0, 0, 32'h0};
        vecs[22] = '{0, 0, 32'h0,  0, 32'h0,  0, 32'h80, 1, 32'h7C, 32'h2000001F, 0, 0, 0, 32'h0};
        vecs[23] = '{0, 0, 32'h0,  0, 32'h0,  0, 32'h80, 0, 32'h7C, 32'h2000001F, 0, 1, 2, 32'h80};

        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        #1;
        check_outputs("reset", 32'h0, 0, 32'h0, 32'h0, 0, 0, 2'd0, 32'h0);
        check("reset.FaultPC", FaultPC, 32'h0);

        // Directed table: inputs held across one rising edge, outputs checked after.
        for (int i = 0; i < NVEC; i++) begin
            Stall = vecs[i].stall; Jump = vecs[i].jump; JumpTarget = vecs[i].jt;
            BranchTaken = vecs[i].br; BranchTarget = vecs[i].bt; Resume = vecs[i].resume;
            @(posedge clk);
            #1;
            check_outputs($sformatf("vec%0d", i), vecs[i].addr, vecs[i].valid, vecs[i].pcout,
                          vecs[i].iout, vecs[i].halted, vecs[i].fault, vecs[i].cause, vecs[i].fpc);
        end

        // Reset asserted mid-FAULT, between clock edges, must act immediately.
        Stall = 1'b0; Jump = 1'b0; BranchTaken = 1'b0; Resume = 1'b0;
        #2;
        reset = 1'b1;
        #1;
        check_outputs("async_reset", 32'h0, 0, 32'h0, 32'h0, 0, 0, 2'd0, 32'h0);
        check("async_reset.FaultPC", FaultPC, 32'h0);
        @(posedge clk);
        #1;
        check_outputs("held_reset", 32'h0, 0, 32'h0, 32'h0, 0, 0, 2'd0, 32'h0);

        // Randomized run against the behavioural model.
        for (int i = 0; i < int'(DEPTH); i++)
            rom[i] = ($urandom_range(0, 9) == 0) ? HALTW : $urandom();
        model_reset();
        @(negedge clk);
        reset = 1'b0;
        for (int n = 0; n < int'(NRAND); n++) begin
            Stall        = ($urandom_range(0, 3) == 0);
            Jump         = ($urandom_range(0, 11) == 0);
            BranchTaken  = ($urandom_range(0, 11) == 0);
            JumpTarget   = rand_target();
            BranchTarget = rand_target();
            Resume       = ($urandom_range(0, 2) == 0);
            @(posedge clk);
            model_step(Stall, Jump, JumpTarget, BranchTaken, BranchTarget, Resume);
            #1;
            check_outputs($sformatf("rand%0d", n), m_pc, m_valid, m_pcout, m_iout,
                          m_mode == 2, m_mode == 3, m_cause, m_fpc);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/instruction_fetch_controller.md
Name: instruction_fetch_controller

Overview:
Sequences the asynchronous-read program memory ROM for the MIPS core.
- Owns the program counter and drives the word-aligned byte address into the ROM.
- Registers the returned word into a fetch output register (instruction + PC + valid).
- Applies stall, branch/jump redirects, a HALT word, and address-fault detection.
- Sits between the program memory and the decode stage.

Parameters:
MEMORY_DEPTH, 32, ROM depth in words; the legal fetch range is byte addresses 0 .. MEMORY_DEPTH*4-4.
DATA_WIDTH, 32, width of addresses and instruction words.
RESET_VECTOR, 0, PC value loaded on reset and on fault recovery.
HALT_WORD, 32'h0000000C, instruction encoding (syscall) that halts fetch after it is issued.

Ports:
clk  input  1  clock, rising edge.
reset  input  1  asynchronous, active-high reset.
Stall  input  1  hold the PC and the fetch output register.
Jump  input  1  redirect the PC to JumpTarget.
JumpTarget  input  DATA_WIDTH  jump destination (byte address).
BranchTaken  input  1  redirect the PC to BranchTarget.
BranchTarget  input  DATA_WIDTH  branch destination (byte address).
Resume  input  1  leave HALT or FAULT.
Instruction  input  DATA_WIDTH  ROM read data (combinational from Address).
Address  output  DATA_WIDTH  ROM address; equals PC combinationally.
InstructionOut  output  DATA_WIDTH  registered fetched instruction.
PCOut  output  DATA_WIDTH  registered PC of InstructionOut.
PCPlus4  output  DATA_WIDTH  PCOut+4, combinational.
InstrValid  output  1  InstructionOut is valid this cycle.
Halted  output  1  FSM is in HALT.
Fault  output  1  FSM is in FAULT.
FaultCause  output  2  01 = misaligned, 10 = out of range, 00 = none.
FaultPC  output  DATA_WIDTH  PC that faulted.

Behaviour:
Reset (asynchronous, any state):
- PC=RESET_VECTOR; InstructionOut=0, PCOut=0, InstrValid=0, FaultCause=0, FaultPC=0; state=IDLE.

States: IDLE, RUN, HALT, FAULT.
- IDLE: one cycle with InstrValid=0, then RUN unconditionally. Inputs are ignored.
- RUN, evaluated each rising edge in this priority order:
  1. Fault check on the current PC. PC[1:0]!=0 gives cause 01; PC >= MEMORY_DEPTH*4 gives cause 10; misaligned wins if both apply. On a fault: FaultPC<=PC, FaultCause<=cause, InstrValid<=0, PC held, go to FAULT.
  2. Redirect. Jump takes priority over BranchTaken. PC<=target, InstrValid<=0 (the fetch at the current PC is squashed). A redirect overrides Stall.
  3. Stall=1: PC, InstructionOut, PCOut and InstrValid all hold.
  4. Otherwise: InstructionOut<=Instruction, PCOut<=PC, InstrValid<=1, PC<=PC+4 (wraps modulo 2^DATA_WIDTH). If Instruction==HALT_WORD, go to HALT after issuing it.
- HALT:
  - Halted=1. InstrValid drops to 0 on the first HALT cycle; PC holds at halt PC+4.
  - Stall and redirects are ignored.
  - Resume=1 returns to RUN; fetch continues from PC on the next cycle.
- FAULT:
  - Fault=1; FaultCause and FaultPC hold; InstrValid=0.
  - Resume=1: PC<=RESET_VECTOR, FaultCause<=0, go to IDLE.
- A redirect target is not checked on the cycle it is loaded. It is checked on the next RUN cycle, before issue.
- Decoding: Halted and Fault are decoded from the state register; FaultCause is valid only while Fault=1.
- Latency: an instruction at PC appears on InstructionOut one clock after PC is presented on Address.
- Reset asserted mid-redirect, mid-stall or in HALT/FAULT forces the reset values immediately.

Test Plan:
- Reset, then run free with ROM words 0x20080001, 0x20090002 → Address sequence 0, 0, 4, 8. InstrValid=0 for the first cycle after reset. PCOut/InstructionOut = 0/0x20080001, then 4/0x20090002.
- Stall=1 for 3 cycles at PC=8 → Address stays 8; InstructionOut and PCOut unchanged; PC=0xC after release.
- Same-cycle Jump (JumpTarget=0x40) and BranchTaken (BranchTarget=0x20), also with Stall=1 → next Address=0x40; InstrValid=0 for one cycle; next valid PCOut=0x40.
- ROM word at 0x10 = 0x0000000C → issued with InstrValid=1, then Halted=1 and InstrValid=0 with PC=0x14. Resume → next valid PCOut=0x14.
- Jump to 0x42 → Fault=1, FaultCause=01, FaultPC=0x42. Resume → Address=0 after IDLE, Fault=0.
- Sequential fetch to 0x80 with MEMORY_DEPTH=32 → FaultCause=10, FaultPC=0x80. Assert reset mid-FAULT → all outputs return to reset values asynchronously.
